// File: rtl/compensation_mem_ctrl_pkg.sv
// Purpose: shared constants, state encoding and sizing helper for the compensation memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package compensation_mem_ctrl_pkg;

  // One compensation weight per memory entry.
  localparam int CW_WIDTH  = 3;
  // Column offsets walked per run; each read returns one column of SIZE weights.
  localparam int NUM_COLS  = 3;
  localparam int COL_WIDTH = 2;

  // The memory holds NUM_COLS columns of SIZE weights.
  function automatic int cmem_size(input int size);
    return size * NUM_COLS;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LOADED = 3'd2,
    S_READ   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

endpackage

// File: rtl/compensation_mem_ctrl.sv
// Purpose: sequences compensation-memory writes during load and column reads during a run.
// Latency: write 1 cycle after handshake; run_start/col_adv to comp_valid 2 cycles.
// Backpressure: cw_ready only in LOAD; reads paced by col_adv from the array.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   load_start, cw_valid/cw_data/cw_ready   weight image load stream
//   run_start, col_adv                 run trigger and column-consumed handshake
//   Wr_en/Wr_Addr/Compensation_Weight  memory write port
//   Rd_en/Rd_Addr, comp_valid          memory read port and column-valid flag
//   loaded, busy, done                 status
module compensation_mem_ctrl
  import compensation_mem_ctrl_pkg::*;
#(
  parameter int SIZE            = 8,
  parameter int CMEM_SIZE       = cmem_size(SIZE),
  parameter int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic                       cw_valid,
  input  logic [CW_WIDTH-1:0]        cw_data,
  output logic                       cw_ready,
  input  logic                       run_start,
  input  logic                       col_adv,
  output logic                       Wr_en,
  output logic [CMEM_ADDR_WIDTH-1:0] Wr_Addr,
  output logic [CW_WIDTH-1:0]        Compensation_Weight,
  output logic                       Rd_en,
  output logic [COL_WIDTH-1:0]       Rd_Addr,
  output logic                       comp_valid,
  output logic                       loaded,
  output logic                       busy,
  output logic                       done
);

  localparam logic [CMEM_ADDR_WIDTH-1:0] LAST_ADDR = CMEM_ADDR_WIDTH'(CMEM_SIZE - 1);
  localparam logic [COL_WIDTH-1:0]       LAST_COL  = COL_WIDTH'(NUM_COLS - 1);

  state_t                     state;
  logic [CMEM_ADDR_WIDTH-1:0] wr_cnt;
  logic [COL_WIDTH-1:0]       col;

  // Only combinational output: ready is a pure state decode, no input path.
  assign cw_ready = (state == S_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      wr_cnt              <= '0;
      col                 <= '0;
      Wr_en               <= 1'b0;
      Wr_Addr             <= '0;
      Compensation_Weight <= '0;
      Rd_en               <= 1'b0;
      Rd_Addr             <= '0;
      comp_valid          <= 1'b0;
      loaded              <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      // Strobes default low; address/data registers hold between strobes.
      Wr_en <= 1'b0;
      Rd_en <= 1'b0;
      done  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (load_start) begin
            state  <= S_LOAD;
            wr_cnt <= '0;
            busy   <= 1'b1;
          end
        end

        S_LOAD: begin
          // cw_ready is 1 throughout LOAD, so cw_valid alone is the handshake.
          if (cw_valid) begin
            Wr_en               <= 1'b1;
            Wr_Addr             <= wr_cnt;
            Compensation_Weight <= cw_data;
            if (wr_cnt == LAST_ADDR) begin
              // Counter parks on the last address instead of wrapping.
              state  <= S_LOADED;
              loaded <= 1'b1;
              busy   <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + CMEM_ADDR_WIDTH'(1);
            end
          end
        end

        S_LOADED: begin
          // The final write lands in this state's first cycle; a read can only
          // follow one cycle later, so write and read never coincide.
          if (run_start) begin
            state   <= S_READ;
            col     <= '0;
            Rd_en   <= 1'b1;
            Rd_Addr <= '0;
            busy    <= 1'b1;
          end else if (load_start) begin
            state  <= S_LOAD;
            wr_cnt <= '0;
            loaded <= 1'b0;
            busy   <= 1'b1;
          end
        end

        S_READ: begin
          // Memory read is registered: data is valid from the first WAIT cycle.
          state      <= S_WAIT;
          comp_valid <= 1'b1;
        end

        S_WAIT: begin
          if (col_adv) begin
            comp_valid <= 1'b0;
            if (col == LAST_COL) begin
              state <= S_LOADED;
              col   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= S_READ;
              col     <= col + COL_WIDTH'(1);
              Rd_en   <= 1'b1;
              Rd_Addr <= col + COL_WIDTH'(1);
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          comp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compensation_mem_ctrl.sv
// Purpose: self-checking bench for compensation_mem_ctrl against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_compensation_mem_ctrl;

  localparam int CMEM = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, cw_valid, run_start, col_adv;
  logic [2:0] cw_data;
  logic       cw_ready, Wr_en, Rd_en, comp_valid, loaded, busy, done;
  logic [4:0] Wr_Addr;
  logic [2:0] Compensation_Weight;
  logic [1:0] Rd_Addr;

  compensation_mem_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .load_start          (load_start),
    .cw_valid            (cw_valid),
    .cw_data             (cw_data),
    .cw_ready            (cw_ready),
    .run_start           (run_start),
    .col_adv             (col_adv),
    .Wr_en               (Wr_en),
    .Wr_Addr             (Wr_Addr),
    .Compensation_Weight (Compensation_Weight),
    .Rd_en               (Rd_en),
    .Rd_Addr             (Rd_Addr),
    .comp_valid          (comp_valid),
    .loaded              (loaded),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event logs collected mid-cycle; checks compare them with the model afterwards.
  int         wr_addr_q[$], wr_dat_q[$], wr_cyc_q[$];
  int         rd_addr_q[$], rd_cyc_q[$];
  int         cv_cyc_q[$], done_cyc_q[$];
  int         overlap = 0;
  logic       prev_cv = 1'b0;
  logic [2:0] exp_q[$];

  always @(negedge clk) begin
    if (Wr_en) begin
      wr_addr_q.push_back(32'(Wr_Addr));
      wr_dat_q.push_back(32'(Compensation_Weight));
      wr_cyc_q.push_back(cyc);
    end
    if (Rd_en) begin
      rd_addr_q.push_back(32'(Rd_Addr));
      rd_cyc_q.push_back(cyc);
    end
    if (comp_valid && !prev_cv) cv_cyc_q.push_back(cyc);
    if (done) done_cyc_q.push_back(cyc);
    if (Wr_en && Rd_en) overlap++;
    prev_cv = comp_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    cv_cyc_q.delete();  done_cyc_q.delete();
  endtask

  // Load a full image. In random mode cw_valid toggles at 50% and stray
  // run_start/load_start pulses are thrown in; both must be ignored in LOAD.
  task automatic load_image(input bit rnd);
    int acc, guard, ls;
    clear_logs();
    exp_q.delete();
    load_start = 1'b1;
    ls = cyc;
    tick();
    load_start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < CMEM && guard < 2000) begin
      cw_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cw_data    = rnd ? 3'($urandom_range(0, 7)) : 3'(acc % 8);
      run_start  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      load_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cw_valid) begin
        exp_q.push_back(cw_data);
        acc++;
      end
      tick();
      guard++;
      if (guard == 3) chk("loaded_low_while_loading", 32'(loaded), 0);
    end
    cw_valid = 1'b0; run_start = 1'b0; load_start = 1'b0;
    chk("load_guard", 32'(acc), CMEM);
    tick();
    tick();
    chk("wr_count", 32'(wr_addr_q.size()), CMEM);
    for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("wr_data[%0d]", i), 32'(wr_dat_q[i]), 32'(exp_q[i]));
      if (!rnd) chk($sformatf("wr_cycle[%0d]", i), 32'(wr_cyc_q[i]), 32'(ls + 2 + i));
    end
    chk("no_read_during_load", 32'(rd_addr_q.size()), 0);
    chk("loaded_after_load", 32'(loaded), 1);
    chk("cw_ready_after_load", 32'(cw_ready), 0);
    chk("busy_after_load", 32'(busy), 0);
  endtask

  // One full run; the array consumes each column 3 cycles after it appears.
  task automatic do_run(input bit also_load, input bit adv_in_read);
    int rs, g;
    int adv_cyc[3];
    clear_logs();
    run_start  = 1'b1;
    load_start = also_load;
    rs = cyc;
    tick();
    run_start  = 1'b0;
    load_start = 1'b0;
    if (adv_in_read) begin
      col_adv = 1'b1;
      tick();
      col_adv = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      g = 0;
      while (!comp_valid && g < 20) begin
        tick();
        g++;
      end
      chk($sformatf("cv_timeout[%0d]", k), 32'(g < 20), 1);
      repeat (3) begin
        tick();
        chk($sformatf("cv_hold[%0d]", k), 32'(comp_valid), 1);
      end
      col_adv = 1'b1;
      adv_cyc[k] = cyc;
      tick();
      col_adv = 1'b0;
    end
    repeat (3) tick();
    chk("rd_count", 32'(rd_addr_q.size()), 3);
    for (int k = 0; k < rd_addr_q.size() && k < 3; k++) begin
      chk($sformatf("rd_addr[%0d]", k), 32'(rd_addr_q[k]), 32'(k));
      chk($sformatf("rd_cycle[%0d]", k), 32'(rd_cyc_q[k]),
          32'((k == 0) ? rs + 1 : adv_cyc[k-1] + 1));
    end
    chk("cv_rise_count", 32'(cv_cyc_q.size()), 3);
    for (int k = 0; k < cv_cyc_q.size() && k < rd_cyc_q.size(); k++)
      chk($sformatf("cv_after_rd[%0d]", k), 32'(cv_cyc_q[k]), 32'(rd_cyc_q[k] + 1));
    chk("done_count", 32'(done_cyc_q.size()), 1);
    if (done_cyc_q.size() > 0)
      chk("done_cycle", 32'(done_cyc_q[0]), 32'(adv_cyc[2] + 1));
    chk("no_write_in_run", 32'(wr_addr_q.size()), 0);
    chk("wr_rd_overlap", 32'(overlap), 0);
    chk("loaded_after_run", 32'(loaded), 1);
    chk("busy_after_run", 32'(busy), 0);
    chk("rd_addr_holds", 32'(Rd_Addr), 2);
    chk("cv_low_after_run", 32'(comp_valid), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    load_start = 1'b0; cw_valid = 1'b0; cw_data = 3'd0;
    run_start = 1'b0; col_adv = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_wr_en", 32'(Wr_en), 0);
    chk("rst_wr_addr", 32'(Wr_Addr), 0);
    chk("rst_cw", 32'(Compensation_Weight), 0);
    chk("rst_rd_en", 32'(Rd_en), 0);
    chk("rst_rd_addr", 32'(Rd_Addr), 0);
    chk("rst_comp_valid", 32'(comp_valid), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cw_ready", 32'(cw_ready), 0);

    // IDLE ignores weights, run_start and col_adv.
    clear_logs();
    cw_valid = 1'b1; cw_data = 3'd5; run_start = 1'b1; col_adv = 1'b1;
    repeat (5) tick();
    cw_valid = 1'b0; run_start = 1'b0; col_adv = 1'b0;
    tick();
    chk("idle_no_write", 32'(wr_addr_q.size()), 0);
    chk("idle_no_read", 32'(rd_addr_q.size()), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cw_ready", 32'(cw_ready), 0);

    // Back-to-back load, then a 50% valid load with stray start pulses.
    load_image(1'b0);
    load_image(1'b1);

    // Runs: plain, simultaneous run/load with col_adv in READ, plain repeat.
    do_run(1'b0, 1'b0);
    do_run(1'b1, 1'b1);
    do_run(1'b0, 1'b0);

    // Reset in the middle of a load.
    clear_logs();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    cw_valid = 1'b1;
    g = 0;
    while (!(Wr_en && Wr_Addr == 5'd10) && g < 50) begin
      cw_data = 3'($urandom_range(0, 7));
      tick();
      g++;
    end
    chk("midload_reach_addr10", 32'(g < 50), 1);
    rst = 1'b1;
    #1;
    chk("midload_rst_loaded", 32'(loaded), 0);
    chk("midload_rst_busy", 32'(busy), 0);
    chk("midload_rst_cw_ready", 32'(cw_ready), 0);
    chk("midload_rst_wr_en", 32'(Wr_en), 0);
    cw_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_loaded", 32'(loaded), 0);
    chk("post_rst_wr_addr", 32'(Wr_Addr), 0);
    load_image(1'b0);
    do_run(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
